// File: rtl/sdff_scan_bank_if.sv
// Bus bundle for sdff_scan_bank: capture/scan controls and data in, register state and scan status out.
interface sdff_scan_bank_if #(
    parameter int WIDTH  = 8,
    parameter int CHAINS = 2
);
    logic              EN;
    logic              SE;
    logic [WIDTH-1:0]  D;
    logic [CHAINS-1:0] SI;
    logic [WIDTH-1:0]  Q;
    logic [CHAINS-1:0] SO;
    logic              DONE;

    modport master (output EN, SE, D, SI, input Q, SO, DONE);
    modport slave  (input EN, SE, D, SI, output Q, SO, DONE);
endinterface

// File: rtl/sdff_scan_bank.sv
// Mux-scan register bank: WIDTH bits split into CHAINS equal scan segments,
// with functional capture, hold, serial shift and a full-segment shift counter.
module sdff_scan_bank #(
    parameter int               WIDTH     = 8,
    parameter int               CHAINS    = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b1}}
) (
    input logic              CLK,
    input logic              RST,
    sdff_scan_bank_if.slave  bus
);
    localparam int L     = WIDTH / CHAINS;
    localparam int CNT_W = (L > 1) ? $clog2(L) : 1;

    generate
        if (WIDTH < 1 || CHAINS < 1 || (WIDTH % CHAINS) != 0) begin : g_bad_params
            $error("sdff_scan_bank: CHAINS must divide WIDTH exactly");
        end
    endgenerate

    logic [WIDTH-1:0] q_p0;
    logic [WIDTH-1:0] shifted;
    logic [CNT_W-1:0] cnt_p0;
    logic             done_p0;

    // Each segment shifts toward its MSB, taking SI[c] in at its LSB.
    always_comb begin
        shifted = '0;
        for (int c = 0; c < CHAINS; c++) begin
            shifted[c*L] = bus.SI[c];
            for (int i = 1; i < L; i++) begin
                shifted[c*L+i] = q_p0[c*L+i-1];
            end
        end
    end

    // Register update: RST > SE > EN > hold; counter only advances on consecutive shifts.
    always_ff @(posedge CLK) begin
        if (RST) begin
            q_p0    <= RESET_VAL;
            cnt_p0  <= '0;
            done_p0 <= 1'b0;
        end else if (bus.SE) begin
            q_p0 <= shifted;
            if (cnt_p0 == CNT_W'(L - 1)) begin
                cnt_p0  <= '0;
                done_p0 <= 1'b1;
            end else begin
                cnt_p0  <= cnt_p0 + 1'b1;
                done_p0 <= 1'b0;
            end
        end else begin
            if (bus.EN) begin
                q_p0 <= bus.D;
            end
            cnt_p0  <= '0;
            done_p0 <= 1'b0;
        end
    end

    always_comb begin
        bus.SO = '0;
        for (int c = 0; c < CHAINS; c++) begin
            bus.SO[c] = q_p0[c*L+L-1];
        end
    end

    assign bus.Q    = q_p0;
    assign bus.DONE = done_p0;
endmodule
